// File: rtl/popcount_pkg.sv
// popcount_pkg: shared types and helpers for the popcount sequencer slice.
//   state_t         - sequencer FSM state encoding
//   cnt_width()     - result/count width for an operand width w ($clog2(w+1))
//   timeout_default - default RUN-state watchdog limit (2*w+8)
package popcount_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int timeout_default(input int w);
    return 2 * w + 8;
  endfunction

  localparam int DEF_W           = 8;
  localparam int DEF_TIMEOUT_CYC = 2 * DEF_W + 8;

endpackage

// File: rtl/popcount_if.sv
// popcount_if: operand and result valid/ready streams of the popcount sequencer.
//   in_valid/in_ready/in_data       operand stream (producer -> sequencer)
//   res_valid/res_ready/res_count   result stream (sequencer -> consumer)
//   res_err                         result aborted by watchdog
// Modports: slave = sequencer side, master = producer/consumer side.
interface popcount_if
  import popcount_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = cnt_width(W)
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_err;

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_count, res_err
  );

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_count, res_err
  );
endinterface

// File: rtl/popcount_wdog.sv
// popcount_wdog: clear/enable/expire cycle counter guarding the RUN state.
//   clk       in  clock
//   reset_n   in  asynchronous active-low reset
//   i_clr     in  synchronous clear (has priority over enable)
//   i_en      in  count enable
//   o_expire  out high during the LIMIT-th consecutive enabled cycle
module popcount_wdog #(
  parameter int LIMIT = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CNTW = $clog2(LIMIT + 1);

  logic [CNTW-1:0] r_cnt;

  // Counter starts at 0 on the first enabled cycle, so LIMIT-1 marks the LIMIT-th.
  assign o_expire = i_en && (r_cnt == CNTW'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end
endmodule

// File: rtl/popcount_seq.sv
// popcount_seq: upstream sequencer for the pc/po ones-counter core.
// Accepts an operand word, presents it on core_a, drives core_s, waits for
// core_pronto, captures core_b and returns it on the result stream, then
// completes the s/pronto return-to-idle handshake before the next word.
// Ports:
//   clk          in   clock (rising edge)
//   reset_n      in   asynchronous active-low reset
//   io           slave popcount_if: in_valid/in_ready/in_data, res_valid/res_ready/res_count/res_err
//   core_a       out  operand bus to core A register
//   core_s       out  core start/hold line
//   core_pronto  in   core done
//   core_b       in   core ones count, valid while core_pronto=1
// Build option: define POPCOUNT_SEQ_TIMEOUT_EN to add the RUN-state watchdog
// (parameter TIMEOUT_CYC); otherwise res_err is constant 0 and RUN waits forever.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = cnt_width(W)
`ifdef POPCOUNT_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = timeout_default(W)
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  popcount_if.slave     io,
  output logic [W-1:0]  core_a,
  output logic          core_s,
  input  logic          core_pronto,
  input  logic [CW-1:0] core_b
);

  state_t        r_state;
  logic [W-1:0]  r_op;
  logic          r_in_ready;
  logic          r_core_s;
  logic          r_res_valid;
  logic [CW-1:0] r_res_count;
  logic          w_accept;
  logic          w_res_take;

  assign w_accept   = io.in_valid & r_in_ready;
  assign w_res_take = r_res_valid & io.res_ready;

  assign core_a       = r_op;
  assign core_s       = r_core_s;
  assign io.in_ready  = r_in_ready;
  assign io.res_valid = r_res_valid;
  assign io.res_count = r_res_count;

`ifdef POPCOUNT_SEQ_TIMEOUT_EN
  logic r_res_err;
  logic w_expire;

  assign io.res_err = r_res_err;

  popcount_wdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (r_state != ST_RUN),
    .i_en     (r_state == ST_RUN),
    .o_expire (w_expire)
  );
`else
  assign io.res_err = 1'b0;
`endif

  // Outputs are updated on the transition into each state, so every output
  // register already holds its new-state value during the state's first cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_in_ready  <= 1'b0;
      r_core_s    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_count <= '0;
`ifdef POPCOUNT_SEQ_TIMEOUT_EN
      r_res_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // in_ready is low in the first cycle after reset release.
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_op       <= io.in_data;
            r_in_ready <= 1'b0;
`ifdef POPCOUNT_SEQ_TIMEOUT_EN
            r_res_err  <= 1'b0;
`endif
            r_state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_core_s <= 1'b1;
          r_state  <= ST_RUN;
        end

        ST_RUN: begin
          if (core_pronto) begin
            r_res_count <= core_b;
            r_res_valid <= 1'b1;
            r_state     <= ST_HOLD;
`ifdef POPCOUNT_SEQ_TIMEOUT_EN
          end else if (w_expire) begin
            r_res_count <= '0;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= ST_HOLD;
`endif
          end
        end

        ST_HOLD: begin
          if (w_res_take) begin
            r_res_valid <= 1'b0;
            r_core_s    <= 1'b0;
            r_state     <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (!core_pronto) begin
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: self-checking bench for popcount_seq with a behavioural
// shift-and-count core attached. Expected results come from $countones of each
// issued word and are queued; a monitor pops and compares on every result handshake.
module tb_popcount_seq;
  import popcount_pkg::*;

  localparam int W  = 8;
  localparam int CW = cnt_width(W);

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  popcount_if #(.W(W), .CW(CW)) u_if ();

  logic [W-1:0]  core_a;
  logic          core_s;
  logic          core_pronto;
  logic [CW-1:0] core_b;

  popcount_seq #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .io          (u_if),
    .core_a      (core_a),
    .core_s      (core_s),
    .core_pronto (core_pronto),
    .core_b      (core_b)
  );

  // Behavioural ones-counter core: loads A while s=0, shifts/counts while s=1,
  // raises pronto once A is exhausted and holds it until s falls.
  logic [W-1:0]  m_a;
  logic [CW-1:0] m_cnt;
  logic          m_done;
  bit            stub_pronto = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_a    <= '0;
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (!core_s) begin
      m_a    <= core_a;
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (!m_done) begin
      if (m_a == '0) begin
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt + CW'(m_a[0]);
        m_a   <= m_a >> 1;
      end
    end
  end

  assign core_pronto = m_done & ~stub_pronto;
  assign core_b      = m_done ? m_cnt : '0;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   rr_random = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    e.cnt = CW'($countones(d));
    e.err = 1'b0;
    return e;
  endfunction

  // Monitor: a handshake completes on the posedge after a negedge with valid&ready.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && u_if.res_valid && u_if.res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got count=%0d err=%0d expected no result",
                 u_if.res_count, u_if.res_err);
      end else begin
        e = sb.pop_front();
        check("res_count", 32'(u_if.res_count), 32'(e.cnt));
        check("res_err", 32'(u_if.res_err), 32'(e.err));
      end
    end
  end

  // Random result backpressure, driven just after the active edge.
  always @(posedge clk) begin
    #1;
    if (rr_random) u_if.res_ready = 1'($urandom_range(0, 1));
  end

  // Present d until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [W-1:0] d, input exp_t e, input bit push);
    bit ok;
    ok = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (u_if.in_ready) begin
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    u_if.in_valid = 1'b0;
    if (!ok) check("send_accept_timeout", 32'(ok), 32'd1);
  endtask

  // Returns at a negedge where res_valid is high.
  task automatic wait_res_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (u_if.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'(ok), 32'd1);
  endtask

  // Waits until all queued results are consumed and the sequencer is idle.
  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && u_if.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.res_ready = 1'b1;

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(u_if.in_ready), 32'd0);
    check("rst_core_s", 32'(core_s), 32'd0);
    check("rst_res_valid", 32'(u_if.res_valid), 32'd0);
    check("rst_res_err", 32'(u_if.res_err), 32'd0);
    check("rst_res_count", 32'(u_if.res_count), 32'd0);
    check("rst_core_a", 32'(core_a), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", 32'(u_if.in_ready), 32'd1);

    // 1: 0xB5 -> 5; core_s timing
    send(8'hB5, model(8'hB5), 1'b1);
    check("t1_load_core_s", 32'(core_s), 32'd0);
    check("t1_load_in_ready", 32'(u_if.in_ready), 32'd0);
    check("t1_core_a", 32'(core_a), 32'hB5);
    @(posedge clk);
    #1;
    check("t1_run_core_s", 32'(core_s), 32'd1);
    wait_res_valid("t1_res_valid_timeout");
    check("t1_hold_core_s", 32'(core_s), 32'd1);
    @(posedge clk);
    #1;
    check("t1_release_core_s", 32'(core_s), 32'd0);
    check("t1_release_res_valid", 32'(u_if.res_valid), 32'd0);
    wait_drain("t1_drain_timeout");

    // 2: 0x00 then 0xFF back-to-back
    send(8'h00, model(8'h00), 1'b1);
    wait_res_valid("t2_res_valid_timeout");
    check("t2_hold_in_ready", 32'(u_if.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("t2_release_in_ready", 32'(u_if.in_ready), 32'd0);
    send(8'hFF, model(8'hFF), 1'b1);
    wait_drain("t2_drain_timeout");

    // 3: 0x81 with 10 cycles of backpressure
    u_if.res_ready = 1'b0;
    send(8'h81, model(8'h81), 1'b1);
    wait_res_valid("t3_res_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      check("t3_res_valid", 32'(u_if.res_valid), 32'd1);
      check("t3_res_count", 32'(u_if.res_count), 32'd2);
      check("t3_core_s", 32'(core_s), 32'd1);
      check("t3_pronto", 32'(core_pronto), 32'd1);
      check("t3_in_ready", 32'(u_if.in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    u_if.res_ready = 1'b1;
    wait_drain("t3_drain_timeout");
    repeat (5) @(posedge clk);
    #1;

    // 4: reset mid-RUN on 0x0F, then 0x03 -> 2
    send(8'h0F, model(8'h0F), 1'b1);
    @(posedge clk);
    #1;
    check("t4_in_run", 32'(core_s), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t4_rst_in_ready", 32'(u_if.in_ready), 32'd0);
    check("t4_rst_core_s", 32'(core_s), 32'd0);
    check("t4_rst_res_valid", 32'(u_if.res_valid), 32'd0);
    check("t4_rst_res_count", 32'(u_if.res_count), 32'd0);
    check("t4_rst_core_a", 32'(core_a), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(8'h03, model(8'h03), 1'b1);
    wait_drain("t4_drain_timeout");

    // Random operands with random backpressure
    rr_random = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      send(d, model(d), 1'b1);
    end
    wait_drain("rand_drain_timeout");
    rr_random = 1'b0;
    @(posedge clk);
    #1;
    u_if.res_ready = 1'b1;

    // 5/6: core never signals done
    stub_pronto = 1'b1;
`ifdef POPCOUNT_SEQ_TIMEOUT_EN
    send(8'h5A, exp_t'{cnt: '0, err: 1'b1}, 1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (u_if.res_valid) break;
      n++;
    end
    // LOAD cycle plus TIMEOUT_CYC RUN cycles precede the first HOLD cycle.
    check("t5_cycles_to_hold", 32'(n), 32'(1 + timeout_default(W)));
    check("t5_res_err", 32'(u_if.res_err), 32'd1);
    wait_drain("t5_drain_timeout");
    stub_pronto = 1'b0;
`else
    send(8'h5A, model(8'h5A), 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u_if.res_valid || u_if.res_err) n++;
    end
    check("t6_no_result", 32'(n), 32'd0);
    check("t6_still_run", 32'(core_s), 32'd1);
    check("t6_in_ready", 32'(u_if.in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    stub_pronto = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(8'hC3, model(8'hC3), 1'b1);
    wait_drain("t6_drain_timeout");
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
